// File: rtl/bitrev_spi_slave.sv
// bitrev_spi_slave: SPI slave (CPHA=0) that receives one word MSB-first and
// returns it bit-reversed within the same SS-low frame, all in the system clock domain.
`timescale 1ns/1ps
module bitrev_spi_slave #(
    parameter int DATA_W = 8,
    parameter bit CPOL = 1'b0,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W = 16
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              sck,
    input  logic              ss,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              frame_abort,
    output logic [CNT_W-1:0]  frame_cnt
);
    localparam int BW = $clog2(DATA_W);
    typedef enum logic [1:0] {IDLE, RECV, SEND, DONE} state_t;
    state_t state, state_nx;
    logic [SYNC_STAGES-1:0] sck_sync, ss_sync, mosi_sync;
    logic [SYNC_STAGES:0] rdy;
    logic sck_d, ss_d, armed, skip;
    logic sck_s, ss_s, mosi_s, sample_edge, shift_edge, ss_fall, ss_rise, last_bit;
    logic [BW-1:0] bit_cnt;
    logic [DATA_W-1:0] rx_shift, tx_shift, rx_word, rx_rev;
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sck_sync  <= {SYNC_STAGES{CPOL}};
            ss_sync   <= '1;
            mosi_sync <= '0;
            sck_d     <= CPOL;
            ss_d      <= 1'b1;
            rdy       <= '0;
            armed     <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sck_d     <= sck_s;
            ss_d      <= ss_s;
            rdy       <= {rdy[SYNC_STAGES-1:0], 1'b1};
            // a frame may start only after SS has been seen high post-reset
            armed     <= armed | (rdy[SYNC_STAGES] & ss_s);
        end
    end
    assign sck_s       = sck_sync[SYNC_STAGES-1];
    assign ss_s        = ss_sync[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync[SYNC_STAGES-1];
    assign sample_edge = CPOL ? (sck_d & ~sck_s) : (sck_s & ~sck_d);
    assign shift_edge  = (sck_s ^ sck_d) & ~sample_edge;
    assign ss_fall     = armed & ss_d & ~ss_s;
    assign ss_rise     = ~ss_d & ss_s;
    assign last_bit    = sample_edge & (bit_cnt == '0);
    assign rx_word     = {rx_shift[DATA_W-2:0], mosi_s};
    always_comb begin
        rx_rev = '0;
        for (int i = 0; i < DATA_W; i++)
            rx_rev[i] = rx_word[DATA_W-1-i];
    end
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (ss_fall) state_nx = RECV;
            RECV:    if (last_bit) state_nx = SEND;
            SEND:    if (last_bit) state_nx = DONE;
            default: state_nx = state;
        endcase
        if (ss_rise) state_nx = IDLE;
    end
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_abort <= 1'b0;
            frame_cnt   <= '0;
            skip        <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            frame_abort <= ss_rise & ((state == RECV) | (state == SEND));
            if (!ss_rise) begin
                if (state == IDLE && ss_fall)
                    bit_cnt <= BW'(DATA_W-1);
                if ((state == RECV || state == SEND) && sample_edge)
                    bit_cnt <= last_bit ? BW'(DATA_W-1) : bit_cnt - 1'b1;
                if (state == RECV && sample_edge)
                    rx_shift <= rx_word;
                if (state == RECV && last_bit) begin
                    rx_data  <= rx_word;
                    rx_valid <= 1'b1;
                    tx_shift <= rx_rev;
                    skip     <= 1'b1;
                end
                // the first shift edge in SEND closes the last RECV bit
                if (state == SEND && shift_edge) begin
                    skip <= 1'b0;
                    if (!skip)
                        tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                end
                if (state == SEND && last_bit)
                    frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end
    assign miso    = (state == SEND) & tx_shift[DATA_W-1];
    assign miso_oe = state != IDLE;
endmodule

// File: tb/tb_bitrev_spi_slave.sv
// tb_bitrev_spi_slave: directed bench for bitrev_spi_slave with an 8-bit CPOL=0,
// a 16-bit CPOL=1 and a 2-bit-counter instance.
`timescale 1ns/1ps
module tb_bitrev_spi_slave;
    localparam int HALF = 60;
    logic clk = 1'b0, resetn = 1'b0;
    always #5 clk = ~clk;
    logic sck8 = 1'b0, ss8 = 1'b1, mosi8 = 1'b0;
    logic sck16 = 1'b1, ss16 = 1'b1, mosi16 = 1'b0;
    logic miso8, oe8, rxv8, ab8;
    logic [7:0] rxd8;
    logic [15:0] cnt8;
    logic miso16, oe16, rxv16, ab16;
    logic [15:0] rxd16, cnt16;
    logic misoc, oec, rxvc, abc;
    logic [7:0] rxdc;
    logic [1:0] cntc;
    int checks = 0, failures = 0;
    int nv8 = 0, na8 = 0, nv16 = 0, na16 = 0;
    logic [31:0] rep;
    logic extra;
    int nv0, na0;

    bitrev_spi_slave #(.DATA_W(8), .CPOL(1'b0), .SYNC_STAGES(2), .CNT_W(16)) u8 (
        .clock(clk), .resetn(resetn), .sck(sck8), .ss(ss8), .mosi(mosi8),
        .miso(miso8), .miso_oe(oe8), .rx_data(rxd8), .rx_valid(rxv8),
        .frame_abort(ab8), .frame_cnt(cnt8));
    bitrev_spi_slave #(.DATA_W(16), .CPOL(1'b1), .SYNC_STAGES(2), .CNT_W(16)) u16 (
        .clock(clk), .resetn(resetn), .sck(sck16), .ss(ss16), .mosi(mosi16),
        .miso(miso16), .miso_oe(oe16), .rx_data(rxd16), .rx_valid(rxv16),
        .frame_abort(ab16), .frame_cnt(cnt16));
    bitrev_spi_slave #(.DATA_W(8), .CPOL(1'b0), .SYNC_STAGES(2), .CNT_W(2)) uc (
        .clock(clk), .resetn(resetn), .sck(sck8), .ss(ss8), .mosi(mosi8),
        .miso(misoc), .miso_oe(oec), .rx_data(rxdc), .rx_valid(rxvc),
        .frame_abort(abc), .frame_cnt(cntc));

    always @(posedge clk) begin
        if (rxv8) nv8++;
        if (ab8) na8++;
        if (rxv16) nv16++;
        if (ab16) na16++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pins(input bit s, input logic c, input logic v, input logic m);
        if (s) begin
            sck16 = c; ss16 = v; mosi16 = m;
        end else begin
            sck8 = c; ss8 = v; mosi8 = m;
        end
    endtask

    // master side: s=0 drives the 8-bit CPOL=0 lines, s=1 the 16-bit CPOL=1 lines
    task automatic frame(input bit s, input logic [31:0] word, input int periods, input int stop,
                         input bit raise, output logic [31:0] reply, output logic ext);
        int w = s ? 16 : 8;
        logic cp = s;
        logic mo, m;
        reply = '0;
        ext = 1'b0;
        pins(s, cp, 1'b0, 1'b0);
        #(2*HALF);
        for (int i = 0; i < periods && i < stop; i++) begin
            mo = (i < w) ? word[w-1-i] : 1'b0;
            pins(s, cp, 1'b0, mo);
            #HALF;
            if (i >= w) begin
                m = s ? miso16 : miso8;
                if (i < 2*w) reply[2*w-1-i] = m;
                else ext = ext | m;
            end
            pins(s, ~cp, 1'b0, mo);
            #HALF;
        end
        pins(s, cp, 1'b0, 1'b0);
        #HALF;
        if (raise) begin
            pins(s, cp, 1'b1, 1'b0);
            #(2*HALF);
        end
    endtask

    initial begin
        logic [7:0] words [4];
        logic [7:0] reps [4];
        logic [1:0] cexp [4];
        words = '{8'h01, 8'h02, 8'h04, 8'h08};
        reps  = '{8'h80, 8'h40, 8'h20, 8'h10};
        cexp  = '{2'd2, 2'd3, 2'd0, 2'd1};
        #20;
        chk("rst_miso", 32'(miso8), 32'd0);
        chk("rst_oe", 32'(oe8), 32'd0);
        chk("rst_rxdata", 32'(rxd8), 32'd0);
        chk("rst_rxvalid", 32'(rxv8), 32'd0);
        chk("rst_abort", 32'(ab8), 32'd0);
        chk("rst_cnt", 32'(cnt8), 32'd0);
        chk("rst_oe16", 32'(oe16), 32'd0);
        resetn = 1'b1;
        #100;

        frame(1'b0, 32'hCA, 16, 99, 1'b1, rep, extra);
        chk("ca_reply", rep, 32'h53);
        chk("ca_rxdata", 32'(rxd8), 32'hCA);
        chk("ca_cnt", 32'(cnt8), 32'd1);
        chk("ca_valid_pulses", 32'(nv8), 32'd1);
        chk("ca_oe_after", 32'(oe8), 32'd0);
        chk("cw_cnt_1", 32'(cntc), 32'd1);

        for (int i = 0; i < 4; i++) begin
            frame(1'b0, 32'(words[i]), 16, 99, 1'b1, rep, extra);
            chk("cw_reply", rep, 32'(reps[i]));
            chk("cw_cnt", 32'(cntc), 32'(cexp[i]));
        end
        chk("cw_cnt8", 32'(cnt8), 32'd5);

        na0 = na8;
        nv0 = nv8;
        frame(1'b0, 32'h55, 16, 5, 1'b1, rep, extra);
        chk("ab_pulse", 32'(na8 - na0), 32'd1);
        chk("ab_rxdata", 32'(rxd8), 32'h08);
        chk("ab_cnt", 32'(cnt8), 32'd5);
        chk("ab_novalid", 32'(nv8 - nv0), 32'd0);
        frame(1'b0, 32'h0F, 16, 99, 1'b1, rep, extra);
        chk("ab_next_reply", rep, 32'hF0);
        chk("ab_next_cnt", 32'(cnt8), 32'd6);

        na0 = na8;
        frame(1'b0, 32'hFF, 20, 99, 1'b1, rep, extra);
        chk("oc_reply", rep, 32'hFF);
        chk("oc_miso_after", 32'(extra), 32'd0);
        chk("oc_cnt", 32'(cnt8), 32'd7);
        chk("oc_noabort", 32'(na8 - na0), 32'd0);
        chk("oc_rxdata", 32'(rxd8), 32'hFF);

        frame(1'b1, 32'h8001, 32, 99, 1'b1, rep, extra);
        chk("w16_reply1", rep, 32'h8001);
        chk("w16_oe_between", 32'(oe16), 32'd0);
        frame(1'b1, 32'h1234, 32, 99, 1'b1, rep, extra);
        chk("w16_reply2", rep, 32'h2C48);
        chk("w16_rxdata", 32'(rxd16), 32'h1234);
        chk("w16_cnt", 32'(cnt16), 32'd2);
        chk("w16_valid", 32'(nv16), 32'd2);
        chk("w16_noabort", 32'(na16), 32'd0);

        frame(1'b0, 32'hA5, 20, 12, 1'b0, rep, extra);
        chk("rs_oe_before", 32'(oe8), 32'd1);
        resetn = 1'b0;
        #2;
        chk("rs_oe", 32'(oe8), 32'd0);
        chk("rs_cnt", 32'(cnt8), 32'd0);
        chk("rs_miso", 32'(miso8), 32'd0);
        #8;
        resetn = 1'b1;
        #100;
        nv0 = nv8;
        frame(1'b0, 32'h3C, 16, 99, 1'b0, rep, extra);
        chk("rs_novalid", 32'(nv8 - nv0), 32'd0);
        chk("rs_oe_idle", 32'(oe8), 32'd0);
        ss8 = 1'b1;
        #(2*HALF);
        frame(1'b0, 32'h01, 16, 99, 1'b1, rep, extra);
        chk("rs_recover_reply", rep, 32'h80);
        chk("rs_recover_cnt", 32'(cnt8), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bitrev_spi_slave.md
Name: bitrev_spi_slave

Overview:
Parametrised SPI slave peripheral that receives one DATA_W-bit word MSB-first, then returns it bit-reversed in the same SS-low frame.
Runs in the system clock domain. SCK, SS and MOSI are treated as asynchronous inputs, passed through synchronisers and edge-detected; nothing is clocked by SCK.
Sits on the SoC SPI master's chip-select line as a loopback/test device and reports status (received word, frame count, abort pulse) to the system side.

Parameters:
DATA_W, 8, word width in bits; legal values 2..32.
CPOL, 0, SCK idle level. 0: sample MOSI on SCK rise, shift MISO on SCK fall. 1: sample on fall, shift on rise. CPHA is fixed at 0.
SYNC_STAGES, 2, synchroniser depth for SCK/SS/MOSI; must be at least 2.
CNT_W, 16, width of the completed-frame counter.

Ports:
clock  in  1  system clock; must run at least 4x the SCK frequency.
resetn  in  1  asynchronous active-low reset.
sck  in  1  SPI clock, asynchronous.
ss  in  1  chip select, active low, asynchronous.
mosi  in  1  master-out data, asynchronous.
miso  out  1  slave-out data.
miso_oe  out  1  MISO output enable; the pad drives only when this is 1.
rx_data  out  DATA_W  last fully received word; held until the next word completes.
rx_valid  out  1  one-cycle pulse when a word completes.
frame_abort  out  1  one-cycle pulse when SS rises before the send phase completes.
frame_cnt  out  CNT_W  count of completed frames; wraps modulo 2^CNT_W.

Behaviour:
Reset values (resetn low, asynchronous):
- Synchroniser flops: SCK flops load CPOL, SS flops load 1, MOSI flops load 0.
- state = IDLE; bit_cnt = 0; rx_shift, tx_shift, rx_data, frame_cnt all 0.
- miso = 0, miso_oe = 0, rx_valid = 0, frame_abort = 0.

Edge detection:
- sck_s / ss_s are the synchronised signals.
- sample_edge: sck_s rises when CPOL=0, falls when CPOL=1.
- shift_edge: the opposite SCK transition.
- ss_fall / ss_rise: transitions of ss_s.
- Detection latency from a pad transition is SYNC_STAGES+1 clock cycles.

States and transitions:
- IDLE:
  - On ss_fall go to RECV, with bit_cnt = DATA_W-1 and miso_oe = 1.
  - SCK edges while ss_s is high are ignored.
- RECV:
  - On each sample_edge: rx_shift <= {rx_shift[DATA_W-2:0], mosi_s}; bit_cnt decrements.
  - On the sample_edge where bit_cnt == 0:
    - rx_data <= the completed word; rx_valid pulses on the next cycle.
    - tx_shift <= bit-reverse of the completed word.
    - bit_cnt <= DATA_W-1; go to SEND.
  - shift_edges are ignored in RECV.
- SEND:
  - miso = tx_shift[DATA_W-1] combinationally. The first output bit is therefore valid before the first shift_edge, and so before the master's first sample_edge of SEND.
  - On each shift_edge except the first one after entering SEND: tx_shift shifts left by 1.
    - The first shift_edge after entry is the falling half of the last RECV bit and must not shift.
    - Track it with a one-bit skip flag.
  - Each sample_edge decrements bit_cnt. On the sample_edge where bit_cnt == 0: frame_cnt += 1, go to DONE.
- DONE: miso held at 0, miso_oe stays 1, all SCK edges ignored until ss_rise.

SS handling (priority over all SCK edges in the same cycle):
- ss_rise in any state: go to IDLE, miso_oe = 0, miso = 0.
- If the state was RECV or SEND, frame_abort pulses for one cycle.
  - frame_cnt is not incremented.
  - In RECV, rx_data is unchanged.

Other boundaries:
- ss_fall while not in IDLE cannot occur without an intervening ss_rise; no additional handling.
- Extra SCK pulses beyond 2*DATA_W in one frame have no effect (DONE ignores them).
- frame_cnt wraps from all-ones to 0 with no flag.
- resetn asserted mid-frame returns everything to reset values immediately. After release the block waits in IDLE for the next ss_fall; a still-low SS does not start a frame.

Test Plan:
- DATA_W=8, CPOL=0: frame sends 0xCA -> rx_valid pulses once; rx_data = 0xCA; MISO during the next 8 clocks reads 0,1,0,1,0,0,1,1 (0x53); frame_cnt = 1.
- DATA_W=16, CPOL=1: send 0x8001, then 0x1234 in a second frame -> replies 0x8001 and 0x2C48; frame_cnt = 2; miso_oe is 0 between frames.
- Abort: SS rises after 5 RECV bits -> frame_abort pulses once; rx_data keeps its old value; frame_cnt unchanged; the next full frame with 0x0F returns 0xF0.
- Overclock: 20 SCK periods in one SS-low frame, sending 0xFF -> reply 0xFF; MISO 0 after bit 16; frame_cnt increments by exactly 1; no abort.
- Reset: assert resetn low mid-SEND -> miso_oe = 0 and frame_cnt = 0 asynchronously; after release with SS still low, SCK activity produces no rx_valid.
- CNT_W=2: 5 complete frames -> frame_cnt reads 1,2,3,0,1.
